// File: rtl/dkong_input_pkg.sv
// Shared definitions for the Donkey Kong player-input stage.
// Contents: PS/2 scancodes, joystick bit indices, coin FSM states and the key flag struct.
// Used by dkong_input_ctrl and dkong_coin_pulser; defines no logic of its own.
package dkong_input_pkg;

  // PS/2 set-2 scancodes (low byte; bit 8 of ps2_key is the E0 prefix)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;

  // MiSTer joystick bit map
  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_JUMP   = 4;
  localparam int JB_COIN   = 5;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  // One flag per physical key so partner keys never clear each other
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic space;
    logic ctrl;
    logic f1;
    logic one;
    logic f2;
    logic two;
    logic five;
  } key_flags_t;

endpackage

// File: rtl/dkong_coin_pulser.sv
// Shapes coin requests into fixed-width active-low coin-mech pulses with a forced gap.
// Ports: clk_sys/reset, req (level), o_coin_n (registered), coin_count (pulses issued, wraps).
// Latency: pulse starts one cycle after the req rising edge is seen; one extra edge is queued, more are dropped.
module dkong_coin_pulser
  import dkong_input_pkg::*;
#(
  parameter int COIN_PULSE = 1228800,
  parameter int COIN_GAP   = 1228800,
  parameter int CNT_W      = 21
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             req,
  output logic             o_coin_n,
  output logic [7:0]       coin_count
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(COIN_GAP - 1);

  coin_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       count_q, count_d;
  logic             req_q;
  logic             coin_n_q, coin_n_d;
  logic             req_rise;

  assign req_rise = req & ~req_q;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      count_q  <= '0;
      req_q    <= 1'b0;
      coin_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
      req_q    <= req;
      coin_n_q <= coin_n_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
          count_d = count_q + 8'd1;
        end
      end
      PULSE: begin
        if (req_rise) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // An edge landing on the last gap cycle is honoured like a queued one
          if (pend_q || req_rise) begin
            pend_d  = 1'b0;
            state_d = PULSE;
            cnt_d   = PULSE_LD;
            count_d = count_q + 8'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (req_rise) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output: registered from the current state, so low exactly while state_q was PULSE
  always_comb begin
    coin_n_d = (state_q != PULSE);
  end

  assign o_coin_n   = coin_n_q;
  assign coin_count = count_q;

endmodule

// File: rtl/dkong_input_ctrl.sv
// Player-input conditioning: PS/2 key decode, joystick merge, orientation remap, coin pulse shaping.
// Ports: clk_sys/reset, ps2_key, joystick_0/1, rotate, coin_on_start -> active-low o_*_n controls, coin_count.
// Latency: inputs registered at edge k, outputs registered at k+1 (rotate acts on the next edge); no backpressure.
module dkong_input_ctrl
  import dkong_input_pkg::*;
#(
  parameter int COIN_PULSE = 1228800,
  parameter int COIN_GAP   = 1228800,
  parameter int CNT_W      = 21
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        coin_on_start,
  output logic        o_up_n,
  output logic        o_down_n,
  output logic        o_left_n,
  output logic        o_right_n,
  output logic        o_jump_n,
  output logic        o_start1_n,
  output logic        o_start2_n,
  output logic        o_coin_n,
  output logic [7:0]  coin_count
);

  logic       toggle_q;
  key_flags_t keys_q, keys_d;
  logic [7:0] joy_q;
  logic [6:0] ctl_n_q, ctl_n_d;   // {up, down, left, right, jump, start1, start2}
  logic       ps2_evt, pressed, ext;
  logic       up, down, left, right, jump, start1, start2;
  logic       coin_req;
  logic       unused_joy_hi;

  assign unused_joy_hi = ^{joystick_0[15:8], joystick_1[15:8]};

  assign ps2_evt = ps2_key[10] ^ toggle_q;
  assign pressed = ps2_key[9];
  assign ext     = ps2_key[8];

  // Key decode: arrows ignore the E0 prefix, everything else must be unprefixed
  always_comb begin
    keys_d = keys_q;
    if (ps2_evt) begin
      case (ps2_key[7:0])
        SC_UP:    keys_d.up    = pressed;
        SC_DOWN:  keys_d.down  = pressed;
        SC_LEFT:  keys_d.left  = pressed;
        SC_RIGHT: keys_d.right = pressed;
        SC_SPACE: if (!ext) keys_d.space = pressed;
        SC_CTRL:  if (!ext) keys_d.ctrl  = pressed;
        SC_F1:    if (!ext) keys_d.f1    = pressed;
        SC_1:     if (!ext) keys_d.one   = pressed;
        SC_F2:    if (!ext) keys_d.f2    = pressed;
        SC_2:     if (!ext) keys_d.two   = pressed;
        SC_5:     if (!ext) keys_d.five  = pressed;
        default:  ;
      endcase
    end
  end

  // Merge and remap from registered inputs; rotate is taken live
  always_comb begin
    if (rotate) begin
      up    = keys_q.left  | joy_q[JB_LEFT];
      down  = keys_q.right | joy_q[JB_RIGHT];
      left  = keys_q.down  | joy_q[JB_DOWN];
      right = keys_q.up    | joy_q[JB_UP];
    end else begin
      up    = keys_q.up    | joy_q[JB_UP];
      down  = keys_q.down  | joy_q[JB_DOWN];
      left  = keys_q.left  | joy_q[JB_LEFT];
      right = keys_q.right | joy_q[JB_RIGHT];
    end
    jump     = keys_q.space | keys_q.ctrl | joy_q[JB_JUMP];
    start1   = keys_q.f1    | keys_q.one  | joy_q[JB_START1];
    start2   = keys_q.f2    | keys_q.two  | joy_q[JB_START2];
    coin_req = keys_q.five | joy_q[JB_COIN] | (coin_on_start & (start1 | start2));
    ctl_n_d  = ~{up, down, left, right, jump, start1, start2};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q <= ps2_key[10];   // track the toggle so reset exit is not an event
      keys_q   <= '0;
      joy_q    <= '0;
      ctl_n_q  <= '1;
    end else begin
      toggle_q <= ps2_key[10];
      keys_q   <= keys_d;
      joy_q    <= joystick_0[7:0] | joystick_1[7:0];
      ctl_n_q  <= ctl_n_d;
    end
  end

  dkong_coin_pulser #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP),
    .CNT_W      (CNT_W)
  ) u_coin (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .req        (coin_req),
    .o_coin_n   (o_coin_n),
    .coin_count (coin_count)
  );

  assign {o_up_n, o_down_n, o_left_n, o_right_n, o_jump_n, o_start1_n, o_start2_n} = ctl_n_q;

endmodule
